// File: rtl/zeroheti_pkg.sv
// ----------------------------------------------------------------------------
// zeroheti_pkg
// Shared types and defaults for the compliance-test memory responder.
//   obi_port_e           : identifies which requester port owns a response
//   DEFAULT_* constants  : default geometry and address map
//   be_merge()           : byte-enable merge of a store into an existing word
// ----------------------------------------------------------------------------
package zeroheti_pkg;

    typedef enum logic {
        PORT_INSTR = 1'b0,
        PORT_DATA  = 1'b1
    } obi_port_e;

    localparam int unsigned DEFAULT_MEM_WORDS    = 32'd16384;
    localparam logic [31:0] DEFAULT_BASE_ADDR    = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_TOHOST_ADDR  = 32'h0002_0000;
    localparam int unsigned DEFAULT_STARVE_LIMIT = 32'd4;

    // Replace only the bytes selected by be; unselected bytes keep old_word.
    function automatic logic [31:0] be_merge(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  be);
        logic [31:0] merged;
        merged = old_word;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) begin
                merged[8*b +: 8] = new_word[8*b +: 8];
            end else begin
                merged[8*b +: 8] = old_word[8*b +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/zeroheti_sp_sram.sv
// ----------------------------------------------------------------------------
// zeroheti_sp_sram
// Single-port 32-bit word SRAM with byte-write enables and a one-cycle
// registered read. Contents are deliberately not reset.
//   clk_i   : clock
//   req_i   : access enable for this cycle
//   we_i    : 1 = write (byte-enabled), 0 = read
//   be_i    : byte enables for writes
//   addr_i  : word index
//   wdata_i : write data
//   rdata_o : read data, valid the cycle after a read request
// ----------------------------------------------------------------------------
module zeroheti_sp_sram
    import zeroheti_pkg::*;
#(
    parameter int unsigned Words = 32'd16384,
    parameter int unsigned AddrW = 32'd14
) (
    input  logic             clk_i,
    input  logic             req_i,
    input  logic             we_i,
    input  logic [3:0]       be_i,
    input  logic [AddrW-1:0] addr_i,
    input  logic [31:0]      wdata_i,
    output logic [31:0]      rdata_o
);

    logic [31:0] mem_r [Words];
    logic [31:0] rdata_r;

    // Storage array and read register: writes merge bytes, reads land next cycle.
    always_ff @(posedge clk_i) begin
        if (req_i && we_i) begin
            mem_r[addr_i] <= be_merge(mem_r[addr_i], wdata_i, be_i);
        end
        if (req_i && !we_i) begin
            rdata_r <= mem_r[addr_i];
        end
    end

    assign rdata_o = rdata_r;

endmodule

// File: rtl/zeroheti_compliance_mem.sv
// ----------------------------------------------------------------------------
// zeroheti_compliance_mem
// Memory responder for the compliance-test core. Both core ports share one
// single-port SRAM; an arbiter grants at most one port per cycle, with a
// starvation counter that lets the fetch port win a conflict periodically.
// Out-of-range accesses answer with an error; a store to the tohost register
// latches halt / pass / exit-code status.
//   clk_i, rst_i                 : clock, async active-high reset
//   instr_req/gnt/rvalid/addr/rdata/err : fetch port (read-only)
//   data_req/gnt/rvalid/we/be/addr/wdata/rdata/err : load/store port
//   halt_o, pass_o, exit_code_o  : sticky test-end status
// ----------------------------------------------------------------------------
module zeroheti_compliance_mem
    import zeroheti_pkg::*;
#(
    parameter int unsigned MemWords    = DEFAULT_MEM_WORDS,
    parameter logic [31:0] BaseAddr    = DEFAULT_BASE_ADDR,
    parameter logic [31:0] TohostAddr  = DEFAULT_TOHOST_ADDR,
    parameter int unsigned StarveLimit = DEFAULT_STARVE_LIMIT
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        instr_req_i,
    output logic        instr_gnt_o,
    output logic        instr_rvalid_o,
    input  logic [31:0] instr_addr_i,
    output logic [31:0] instr_rdata_o,
    output logic        instr_err_o,
    input  logic        data_req_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic [31:0] data_rdata_o,
    output logic        data_err_o,
    output logic        halt_o,
    output logic        pass_o,
    output logic [30:0] exit_code_o
);

    localparam int unsigned AddrW = (MemWords > 32'd1) ? $clog2(MemWords) : 32'd1;
    localparam int unsigned CntW  = (StarveLimit > 32'd0) ? $clog2(StarveLimit + 32'd1) : 32'd1;

    logic [CntW-1:0]  starve_cnt_r;
    logic             starve_hit_s;
    logic             instr_gnt_s;
    logic             data_gnt_s;
    logic             any_gnt_s;
    logic [29:0]      acc_word_s;
    logic [29:0]      acc_off_s;
    logic             in_range_s;
    logic             is_store_s;
    logic             tohost_hit_s;
    logic             acc_err_s;
    logic             acc_read_s;
    logic             sram_req_s;
    logic [AddrW-1:0] sram_addr_s;
    logic [31:0]      sram_rdata_s;

    logic             resp_valid_r;
    obi_port_e        resp_port_r;
    logic             resp_err_r;
    logic             resp_read_r;
    logic             halt_r;
    logic             pass_r;
    logic [30:0]      exit_code_r;

    // Byte-offset bits are ignored by design; collected here so they are visibly consumed.
    logic unused_s;
    assign unused_s = ^{instr_addr_i[1:0], data_addr_i[1:0]};

    assign starve_hit_s = (starve_cnt_r == CntW'(StarveLimit));

    // Arbiter: data normally wins a conflict, fetch wins once the starve limit is reached.
    always_comb begin
        instr_gnt_s = 1'b0;
        data_gnt_s  = 1'b0;
        if (rst_i) begin
            instr_gnt_s = 1'b0;
            data_gnt_s  = 1'b0;
        end else if (data_req_i && instr_req_i) begin
            if (starve_hit_s) begin
                instr_gnt_s = 1'b1;
            end else begin
                data_gnt_s = 1'b1;
            end
        end else if (data_req_i) begin
            data_gnt_s = 1'b1;
        end else if (instr_req_i) begin
            instr_gnt_s = 1'b1;
        end else begin
            instr_gnt_s = 1'b0;
            data_gnt_s  = 1'b0;
        end
    end

    assign any_gnt_s = instr_gnt_s | data_gnt_s;

    // Address decode of the granted access; offsets below BaseAddr wrap high and miss the range.
    always_comb begin
        acc_word_s = instr_addr_i[31:2];
        if (data_gnt_s) begin
            acc_word_s = data_addr_i[31:2];
        end else begin
            acc_word_s = instr_addr_i[31:2];
        end
        acc_off_s    = acc_word_s - BaseAddr[31:2];
        in_range_s   = (acc_off_s < 30'(MemWords));
        is_store_s   = data_gnt_s & data_we_i;
        tohost_hit_s = is_store_s & (acc_word_s == TohostAddr[31:2]);
        acc_err_s    = ~in_range_s & ~tohost_hit_s;
        acc_read_s   = in_range_s & ~is_store_s;
        sram_req_s   = any_gnt_s & in_range_s;
        sram_addr_s  = acc_off_s[AddrW-1:0];
    end

    zeroheti_sp_sram #(
        .Words (MemWords),
        .AddrW (AddrW)
    ) u_sram (
        .clk_i   (clk_i),
        .req_i   (sram_req_s),
        .we_i    (is_store_s),
        .be_i    (data_be_i),
        .addr_i  (sram_addr_s),
        .wdata_i (data_wdata_i),
        .rdata_o (sram_rdata_s)
    );

    // Starve counter: counts conflicts lost by the fetch port, cleared on any fetch grant.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            starve_cnt_r <= {CntW{1'b0}};
        end else if (instr_gnt_s) begin
            starve_cnt_r <= {CntW{1'b0}};
        end else if (data_gnt_s && instr_req_i && !starve_hit_s) begin
            starve_cnt_r <= starve_cnt_r + CntW'(1);
        end
    end

    // Response bookkeeping: which port answers next cycle, and whether it errors or reads SRAM.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            resp_valid_r <= 1'b0;
            resp_port_r  <= PORT_INSTR;
            resp_err_r   <= 1'b0;
            resp_read_r  <= 1'b0;
        end else begin
            resp_valid_r <= any_gnt_s;
            resp_port_r  <= data_gnt_s ? PORT_DATA : PORT_INSTR;
            resp_err_r   <= any_gnt_s & acc_err_s;
            resp_read_r  <= any_gnt_s & acc_read_s;
        end
    end

    // Tohost status: first granted store wins and stays until reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            halt_r      <= 1'b0;
            pass_r      <= 1'b0;
            exit_code_r <= 31'd0;
        end else if (tohost_hit_s && !halt_r) begin
            halt_r      <= 1'b1;
            pass_r      <= (data_wdata_i == 32'd1);
            exit_code_r <= data_wdata_i[31:1];
        end
    end

    assign instr_gnt_o    = instr_gnt_s;
    assign data_gnt_o     = data_gnt_s;
    assign instr_rvalid_o = resp_valid_r & (resp_port_r == PORT_INSTR);
    assign data_rvalid_o  = resp_valid_r & (resp_port_r == PORT_DATA);
    assign instr_err_o    = instr_rvalid_o & resp_err_r;
    assign data_err_o     = data_rvalid_o & resp_err_r;
    assign instr_rdata_o  = (instr_rvalid_o && resp_read_r) ? sram_rdata_s : 32'h0000_0000;
    assign data_rdata_o   = (data_rvalid_o && resp_read_r) ? sram_rdata_s : 32'h0000_0000;
    assign halt_o         = halt_r;
    assign pass_o         = pass_r;
    assign exit_code_o    = exit_code_r;

endmodule
